// File: rtl/draw_pair_scheduler.sv
// draw_pair_scheduler
//
// Two-requester round-robin scheduler that turns a granted burst request
// into a stream of pixel-pair writes. Each write cycle presents the even
// address of the pair on Q_a and the odd address on Q_b, both derived from
// one pair index that advances once per completed write.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req[1:0]   level request per requester
//   base0/1    starting pair index per requester (sampled at grant)
//   len0/1     burst length in pairs per requester, 0 = 2^LEN_W (sampled at grant)
//   hold       memory-side stall; suppresses the write of the next cycle
//   gnt[1:0]   one-hot grant pulse, high during the first burst cycle
//   busy       high while a burst is running
//   we         shared write strobe for both memory ports
//   Q_a / Q_b  port addresses {idx,0} / {idx,1}
//   done       one-cycle burst-complete pulse
//   done_id    requester whose burst just completed
//
// Every output comes straight from a flop. Because of that, hold is sampled
// at a clock edge and takes effect on the cycle that follows it: the we flop
// for a cycle is loaded with ~hold at the edge that starts the cycle.

module draw_pair_scheduler #(
  parameter int IDX_W = 13,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [IDX_W-1:0] base0,
  input  logic [IDX_W-1:0] base1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             hold,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             we,
  output logic [IDX_W:0]   Q_a,
  output logic [IDX_W:0]   Q_b,
  output logic             done,
  output logic             done_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  // One extra bit so a zero length can be held as the full 2^LEN_W count.
  logic [LEN_W:0]   remaining;
  logic             owner;
  logic             last;
  logic             pick;
  logic [IDX_W-1:0] sel_base;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W:0]   sel_count;

  // Winner selection: with both requesting, the one not served last wins;
  // with a single request, that requester wins outright.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) begin
      pick = ~last;
    end
    sel_base  = pick ? base1 : base0;
    sel_len   = pick ? len1  : len0;
    sel_count = (sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, sel_len};
  end

  assign Q_a = {idx, 1'b0};
  assign Q_b = {idx, 1'b1};

  // Main sequencer. In RUN, the current value of we says whether this cycle
  // is a real write; only a real write advances idx and remaining, so a
  // stalled cycle leaves the addresses frozen. The write that consumes the
  // last remaining pair moves straight to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      remaining <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      we        <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state     <= RUN;
            owner     <= pick;
            last      <= pick;
            idx       <= sel_base;
            remaining <= sel_count;
            gnt       <= pick ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            we        <= ~hold;
          end
        end
        RUN: begin
          if (we) begin
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
          end
          if (we && (remaining == {{LEN_W{1'b0}}, 1'b1})) begin
            state   <= DONE;
            busy    <= 1'b0;
            we      <= 1'b0;
            done    <= 1'b1;
            done_id <= owner;
          end else begin
            we <= ~hold;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_pair_scheduler.sv
// tb_draw_pair_scheduler
//
// Directed bench for draw_pair_scheduler. Inputs change and outputs are
// sampled 1 ns after each rising edge. A burst is observed cycle by cycle
// by collect_burst, which only records what it sees; each test task then
// compares the recording against hand-computed values.

module tb_draw_pair_scheduler;

  localparam int IDX_W = 13;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [IDX_W-1:0] base0 = '0;
  logic [IDX_W-1:0] base1 = '0;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;
  logic             hold = 1'b0;
  logic [1:0]       gnt;
  logic             busy;
  logic             we;
  logic [IDX_W:0]   Q_a;
  logic [IDX_W:0]   Q_b;
  logic             done;
  logic             done_id;

  int errors = 0;
  int checks = 0;

  logic           cyc_we[$];
  logic [IDX_W:0] cyc_qa[$];
  logic [1:0]     cyc_gnt[$];
  logic [IDX_W:0] wr_qa[$];
  logic [IDX_W:0] wr_qb[$];

  draw_pair_scheduler #(.IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .base0(base0), .base1(base1), .len0(len0), .len1(len1),
    .hold(hold), .gnt(gnt), .busy(busy), .we(we),
    .Q_a(Q_a), .Q_b(Q_b), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  // Pulse reset, release it 1 ns after an edge and wait one edge in IDLE.
  task automatic do_reset();
    req = 2'b00; hold = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Raise req and step to the grant cycle.
  task automatic grant_edge(input logic [1:0] r);
    req = r;
    @(posedge clk); #1;
  endtask

  // Records a burst starting with the current (grant) cycle until done is
  // seen or max_cycles expire. Optionally raises hold for hold_len edges
  // once hold_after writes have been observed.
  task automatic collect_burst(input int max_cycles, input int hold_after, input int hold_len,
                               output int writes, output int cycles,
                               output logic got_done, output logic id);
    int left;
    bit started;
    cyc_we.delete(); cyc_qa.delete(); cyc_gnt.delete(); wr_qa.delete(); wr_qb.delete();
    writes = 0; cycles = -1; got_done = 1'b0; id = 1'b0; left = 0; started = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      cyc_we.push_back(we); cyc_qa.push_back(Q_a); cyc_gnt.push_back(gnt);
      if (done) begin
        got_done = 1'b1; id = done_id; cycles = c;
        break;
      end
      if (we) begin
        writes++;
        wr_qa.push_back(Q_a); wr_qb.push_back(Q_b);
      end
      if (hold_after >= 0 && !started && writes == hold_after) begin
        hold = 1'b1; left = hold_len; started = 1'b1;
      end else if (left > 0) begin
        left--;
        if (left == 0) hold = 1'b0;
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #3;
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_id: got %b want 0", done_id); end
    checks++; if (Q_a !== 14'd0) begin errors++; $display("[TB] FAIL reset_qa: got %0d want 0", Q_a); end
    checks++; if (Q_b !== 14'd1) begin errors++; $display("[TB] FAIL reset_qb: got %0d want 1", Q_b); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    int w, c, bad;
    logic gd, id;
    do_reset();
    base0 = 13'd6144; len0 = 8'd128;
    grant_edge(2'b01);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL single_gnt: got %b want 01", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    checks++; if (we !== 1'b1) begin errors++; $display("[TB] FAIL single_first_we: got %b want 1", we); end
    checks++; if (Q_a !== 14'd12288) begin errors++; $display("[TB] FAIL single_first_qa: got %0d want 12288", Q_a); end
    req = 2'b00; base0 = 13'd0; len0 = 8'd3;
    collect_burst(300, -1, 0, w, c, gd, id);
    checks++; if (w !== 128) begin errors++; $display("[TB] FAIL single_writes: got %0d want 128", w); end
    checks++; if (gd !== 1'b1 || c !== 128) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d want 128", c); end
    checks++; if (id !== 1'b0) begin errors++; $display("[TB] FAIL single_done_id: got %b want 0", id); end
    bad = 0;
    for (int k = 0; k < wr_qa.size(); k++) begin
      if (wr_qa[k] !== 14'(12288 + 2 * k) || wr_qb[k] !== 14'(12289 + 2 * k)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL single_addresses: got %0d bad want 0", bad); end
    checks++; if (cyc_gnt.size() < 2 || cyc_gnt[1] !== 2'b00) begin errors++; $display("[TB] FAIL single_gnt_pulse: gnt stayed high"); end
    @(posedge clk); #1;
    checks++; if ({gnt, we, done, busy} !== 5'b0) begin errors++; $display("[TB] FAIL single_idle_quiet: got %b want 00000", {gnt, we, done, busy}); end
  endtask

  task automatic test_round_robin();
    int w, c;
    logic gd, id;
    do_reset();
    base0 = 13'd100; len0 = 8'd4; base1 = 13'd200; len1 = 8'd4;
    grant_edge(2'b11);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rr_first_gnt: got %b want 01", gnt); end
    checks++; if (Q_a !== 14'd200) begin errors++; $display("[TB] FAIL rr_first_qa: got %0d want 200", Q_a); end
    collect_burst(20, -1, 0, w, c, gd, id);
    checks++; if (w !== 4 || c !== 4 || id !== 1'b0) begin errors++; $display("[TB] FAIL rr_first_burst: got w=%0d c=%0d id=%b want 4 4 0", w, c, id); end
    @(posedge clk); #1;
    checks++; if ({gnt, we, busy} !== 4'b0) begin errors++; $display("[TB] FAIL rr_idle_gap: got %b want 0000", {gnt, we, busy}); end
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL rr_second_gnt: got %b want 10", gnt); end
    checks++; if (Q_a !== 14'd400) begin errors++; $display("[TB] FAIL rr_second_qa: got %0d want 400", Q_a); end
    collect_burst(20, -1, 0, w, c, gd, id);
    checks++; if (w !== 4 || gd !== 1'b1 || id !== 1'b1) begin errors++; $display("[TB] FAIL rr_second_burst: got w=%0d id=%b want 4 1", w, id); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rr_third_gnt: got %b want 01", gnt); end
    req = 2'b00;
    collect_burst(20, -1, 0, w, c, gd, id);
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int w, c, bad;
    logic gd, id;
    do_reset();
    base1 = 13'd20; len1 = 8'd128;
    grant_edge(2'b10);
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL hold_gnt: got %b want 10", gnt); end
    req = 2'b00;
    collect_burst(400, 10, 3, w, c, gd, id);
    checks++; if (w !== 128) begin errors++; $display("[TB] FAIL hold_writes: got %0d want 128", w); end
    checks++; if (gd !== 1'b1 || c !== 131) begin errors++; $display("[TB] FAIL hold_done_cycle: got %0d want 131", c); end
    checks++; if (id !== 1'b1) begin errors++; $display("[TB] FAIL hold_done_id: got %b want 1", id); end
    bad = 0;
    if (cyc_we.size() < 14) bad = 99;
    else begin
      for (int k = 10; k <= 12; k++) if (cyc_we[k] !== 1'b0 || cyc_qa[k] !== 14'd60) bad++;
      if (cyc_we[13] !== 1'b1 || cyc_qa[13] !== 14'd60) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL hold_freeze: got %0d bad cycles want 0", bad); end
    bad = 0;
    for (int k = 0; k < wr_qa.size(); k++) if (wr_qa[k] !== 14'(2 * (20 + k))) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL hold_addresses: got %0d bad want 0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int w, c, bad;
    logic gd, id;
    logic [IDX_W:0] exp_qa[4];
    exp_qa[0] = 14'd16380; exp_qa[1] = 14'd16382; exp_qa[2] = 14'd0; exp_qa[3] = 14'd2;
    do_reset();
    base0 = 13'd8190; len0 = 8'd4;
    grant_edge(2'b01);
    req = 2'b00;
    collect_burst(20, -1, 0, w, c, gd, id);
    checks++; if (w !== 4) begin errors++; $display("[TB] FAIL wrap_writes: got %0d want 4", w); end
    bad = 0;
    for (int k = 0; k < 4 && k < wr_qa.size(); k++) if (wr_qa[k] !== exp_qa[k] || wr_qb[k] !== (exp_qa[k] | 14'd1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL wrap_addresses: got %0d bad want 0", bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero();
    int w, c;
    logic gd, id;
    do_reset();
    base0 = 13'd0; len0 = 8'd0;
    grant_edge(2'b01);
    req = 2'b00;
    collect_burst(600, -1, 0, w, c, gd, id);
    checks++; if (w !== 256) begin errors++; $display("[TB] FAIL len0_writes: got %0d want 256", w); end
    checks++; if (gd !== 1'b1 || c !== 256) begin errors++; $display("[TB] FAIL len0_done_cycle: got %0d want 256", c); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    int n, w, c, seen_done;
    logic gd, id;
    do_reset();
    base0 = 13'd1000; len0 = 8'd128;
    grant_edge(2'b01);
    req = 2'b00;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (we) n++;
      if (n == 50) break;
      @(posedge clk); #1;
    end
    checks++; if (n !== 50) begin errors++; $display("[TB] FAIL midrst_reach50: got %0d want 50", n); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({we, busy, gnt} !== 4'b0) begin errors++; $display("[TB] FAIL midrst_async_ctrl: got %b want 0000", {we, busy, gnt}); end
    checks++; if (Q_a !== 14'd0 || Q_b !== 14'd1) begin errors++; $display("[TB] FAIL midrst_async_addr: got %0d/%0d want 0/1", Q_a, Q_b); end
    seen_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    reset = 1'b1;
    base0 = 13'd50; len0 = 8'd2; req = 2'b01;
    @(posedge clk); #1;
    if (done) seen_done++;
    checks++; if (seen_done !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d pulses want 0", seen_done); end
    checks++; if (gnt !== 2'b01 || Q_a !== 14'd100 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_regrant: got gnt=%b qa=%0d want 01 100", gnt, Q_a); end
    req = 2'b00;
    collect_burst(20, -1, 0, w, c, gd, id);
    checks++; if (w !== 2 || gd !== 1'b1 || id !== 1'b0) begin errors++; $display("[TB] FAIL midrst_burst: got w=%0d done=%b want 2 1", w, gd); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_hold();
    test_wrap();
    test_len_zero();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
